rob_nway: RTL and testbench
===========================

Name: rob_nway

Overview:
Parametrised reorder buffer, successor to the fixed 4-wide ROB. Holds 2**WIDTH_BANK rows of NWAY lanes each; one row is allocated per dispatch group. Supports per-lane valid, NWB writeback ports that clear busy bits, branch-mask kill, and in-order row commit with explicit full/ready back-pressure. Sits between rename/dispatch and the freelist/commit logic.

Parameters:
WIDTH_REG, 7, physical register index width
WIDTH_BRM, 4, branch mask width
WIDTH_BANK, 3, log2 of row count (ROWS = 2**WIDTH_BANK)
WIDTH_WAY, 2, log2 of lanes per row (NWAY = 2**WIDTH_WAY)
NWB, 2, number of writeback ports
WIDTH_TAG, WIDTH_BANK+WIDTH_WAY, derived entry tag width {row, lane}

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_dis_we  in  1  dispatch request for one row
i_dis_pc  in  32  PC of the dispatch group, stored per row
i_dis_val  in  NWAY  per-lane valid
i_dis_prd  in  NWAY*WIDTH_REG  per-lane destination phys reg, lane 0 in LSBs
i_dis_brm  in  NWAY*WIDTH_BRM  per-lane branch mask
o_dis_tag  out  WIDTH_BANK  row that the next dispatch is written to (tail)
o_dis_ready  out  1  ROB not full
i_wb_en  in  NWB  writeback strobe per port
i_wb_tag  in  NWB*WIDTH_TAG  entry tag per port
i_kill_en  in  1  branch mispredict kill
i_kill_mask  in  WIDTH_BRM  mask of killed branches
o_com_en  out  1  head row commits at this edge
o_com_val  out  NWAY  valid lanes of the committing row
o_com_prd  out  NWAY*WIDTH_REG  prd of head row lanes
o_com_pc  out  32  PC of head row

Behaviour:
- State: head, tail (WIDTH_BANK bits, wrap modulo ROWS), count (WIDTH_BANK+1 bits); per entry val, busy, prd, brm; per row pc.
- Reset (async, i_rst_n=0): head=tail=count=0, all val=0 and busy=0. Outputs: o_dis_ready=1, o_dis_tag=0, o_com_en=0, o_com_val=0. Reset mid-operation discards all contents immediately.
- o_dis_ready = (count != ROWS); depends only on count, not on same-cycle commit.
- Dispatch fires when i_dis_we & o_dis_ready: row[tail] lane k gets val=i_dis_val[k] & ~kill_k, busy=i_dis_val[k], prd, brm; pc stored; tail+1. kill_k = i_kill_en & |(brm_k & i_kill_mask). i_dis_we while not ready is ignored.
- Writeback: each enabled port clears busy of entry i_wb_tag at the edge. Multiple ports may hit the same tag. Tags of unallocated entries clear busy harmlessly.
- Kill: at the edge, every stored entry with |(brm & i_kill_mask) gets val=0. Rows are not reclaimed; they drain through commit.
- Commit (combinational from registered state): o_com_en = (count!=0) & for all lanes k: ~val[head][k] | ~busy[head][k]. o_com_val = o_com_en ? val[head] : 0. o_com_prd and o_com_pc always reflect the head row. On the edge with o_com_en=1: head+1 and the row's val is cleared.
- Fully killed row at head: o_com_en=1 with o_com_val=0, one-cycle drain.
- Same-cycle dispatch and commit: count unchanged. Dispatch only: +1. Commit only: -1.
- Same-cycle writeback and kill on one entry: both apply.
- Zero-latency dependence is excluded: writeback or kill affects o_com_en from the following cycle only.

Test Plan:
- Reset, then dispatch 8 rows (val=4'hF, prd=0..31, no writeback) -> o_dis_ready=0 after 8th edge, o_dis_tag wraps to 0, o_com_en stays 0; 9th i_dis_we ignored.
- Dispatch row 0 (prd 0..3, pc=1), writeback tags 0..3 over 2 ports in 2 cycles -> o_com_en=1 the cycle after the last writeback, o_com_prd={3,2,1,0}, o_com_pc=1, head=1 next.
- Dispatch rows with brm 4'b0001 and 4'b0010, kill mask 4'b0010 -> second-branch rows drain with o_com_en=1, o_com_val=0; first-branch rows still wait on busy.
- Full ROB with head ready to commit plus i_dis_we -> commit only; ready rises next cycle; next dispatch lands in freed row, tail wraps 7->0.
- i_dis_val=4'b0101, writeback lanes 0 and 2 -> commit with o_com_val=4'b0101; lanes 1 and 3 ignored.
- Assert i_rst_n=0 mid-stream for 1 ns -> outputs return to reset values immediately; post-reset dispatch gets tag 0.

Source files
------------

// File: rtl/rob_nway.sv
// rob_nway: N-way reorder buffer with 2**WIDTH_BANK rows of NWAY lanes each.
// Each dispatch group takes one row. Writeback ports clear busy bits. A branch
// kill clears val on matching entries, and rows commit in order from the head.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_dis_*              dispatch of one row: we, pc, per-lane val/prd/brm
//   o_dis_tag            row index that the next dispatch writes (tail)
//   o_dis_ready          ROB not full
//   i_wb_en / i_wb_tag   NWB writeback ports, tag = {row, lane}
//   i_kill_en/_mask      branch mispredict kill
//   o_com_*              head-row commit strobe, valid lanes, prd and pc
//
// Handshake: a dispatch is accepted on a rising edge where i_dis_we and
// o_dis_ready are both high. i_dis_we while o_dis_ready is low has no effect
// and needs no hold. o_dis_ready depends only on registered occupancy.
module rob_nway #(
  parameter int WIDTH_REG  = 7,
  parameter int WIDTH_BRM  = 4,
  parameter int WIDTH_BANK = 3,
  parameter int WIDTH_WAY  = 2,
  parameter int NWB        = 2,
  parameter int WIDTH_TAG  = WIDTH_BANK + WIDTH_WAY
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_dis_we,
  input  logic [31:0]                         i_dis_pc,
  input  logic [(2**WIDTH_WAY)-1:0]           i_dis_val,
  input  logic [(2**WIDTH_WAY)*WIDTH_REG-1:0] i_dis_prd,
  input  logic [(2**WIDTH_WAY)*WIDTH_BRM-1:0] i_dis_brm,
  output logic [WIDTH_BANK-1:0]               o_dis_tag,
  output logic                                o_dis_ready,
  input  logic [NWB-1:0]                      i_wb_en,
  input  logic [NWB*WIDTH_TAG-1:0]            i_wb_tag,
  input  logic                                i_kill_en,
  input  logic [WIDTH_BRM-1:0]                i_kill_mask,
  output logic                                o_com_en,
  output logic [(2**WIDTH_WAY)-1:0]           o_com_val,
  output logic [(2**WIDTH_WAY)*WIDTH_REG-1:0] o_com_prd,
  output logic [31:0]                         o_com_pc
);

  localparam int ROWS = 2**WIDTH_BANK;
  localparam int NWAY = 2**WIDTH_WAY;
  localparam logic [WIDTH_BANK:0] FULL_CNT = (WIDTH_BANK+1)'(ROWS);

  logic [WIDTH_BANK-1:0]        head_q, head_d;
  logic [WIDTH_BANK-1:0]        tail_q, tail_d;
  logic [WIDTH_BANK:0]          count_q, count_d;
  logic [NWAY-1:0]              val_q  [ROWS];
  logic [NWAY-1:0]              val_d  [ROWS];
  logic [NWAY-1:0]              busy_q [ROWS];
  logic [NWAY-1:0]              busy_d [ROWS];
  logic [NWAY*WIDTH_REG-1:0]    prd_q  [ROWS];
  logic [NWAY*WIDTH_BRM-1:0]    brm_q  [ROWS];
  logic [31:0]                  pc_q   [ROWS];

  logic            dis_fire;
  logic            com_en;
  logic [NWAY-1:0] head_done;

  // A lane is finished when it is invalid (never valid or killed) or written back.
  assign head_done   = ~val_q[head_q] | ~busy_q[head_q];
  assign com_en      = (count_q != '0) && (&head_done);
  assign o_dis_ready = (count_q != FULL_CNT);
  assign o_dis_tag   = tail_q;
  assign dis_fire    = i_dis_we && o_dis_ready;
  assign o_com_en    = com_en;
  assign o_com_val   = com_en ? val_q[head_q] : '0;
  assign o_com_prd   = prd_q[head_q];
  assign o_com_pc    = pc_q[head_q];

  always_comb begin
    val_d   = val_q;
    busy_d  = busy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Kill stored entries. Killed rows stay allocated and drain through commit.
    if (i_kill_en) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < NWAY; k++) begin
          if (|(brm_q[r][k*WIDTH_BRM +: WIDTH_BRM] & i_kill_mask)) val_d[r][k] = 1'b0;
        end
      end
    end

    // Writeback. Several ports may hit one tag. Stale tags are harmless.
    for (int p = 0; p < NWB; p++) begin
      logic [WIDTH_TAG-1:0] t;
      t = i_wb_tag[p*WIDTH_TAG +: WIDTH_TAG];
      if (i_wb_en[p]) busy_d[t[WIDTH_TAG-1:WIDTH_WAY]][t[WIDTH_WAY-1:0]] = 1'b0;
    end

    if (com_en) begin
      val_d[head_q] = '0;
      head_d        = head_q + 1'b1;
    end

    // Dispatch never targets the head row of a non-empty ROB. The ROB is not
    // full at this point, so the write overrides any kill or writeback to this
    // row. A lane that the kill hits on its way in is stored as invalid.
    if (dis_fire) begin
      for (int k = 0; k < NWAY; k++) begin
        val_d[tail_q][k] = i_dis_val[k] &
                           ~(i_kill_en && (|(i_dis_brm[k*WIDTH_BRM +: WIDTH_BRM] & i_kill_mask)));
      end
      busy_d[tail_q] = i_dis_val;
      tail_d         = tail_q + 1'b1;
    end

    case ({dis_fire, com_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        val_q[r]  <= '0;
        busy_q[r] <= '0;
        prd_q[r]  <= '0;
        brm_q[r]  <= '0;
        pc_q[r]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int r = 0; r < ROWS; r++) begin
        val_q[r]  <= val_d[r];
        busy_q[r] <= busy_d[r];
      end
      if (dis_fire) begin
        prd_q[tail_q] <= i_dis_prd;
        brm_q[tail_q] <= i_dis_brm;
        pc_q[tail_q]  <= i_dis_pc;
      end
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway with default parameters: 8 rows of 4 lanes,
// 7-bit prd, 4-bit brm, 2 writeback ports and a 5-bit tag {row, lane}.
`timescale 1ns/100ps
module tb_rob_nway;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_dis_we;
  logic [31:0] i_dis_pc;
  logic [3:0]  i_dis_val;
  logic [27:0] i_dis_prd;
  logic [15:0] i_dis_brm;
  logic [2:0]  o_dis_tag;
  logic        o_dis_ready;
  logic [1:0]  i_wb_en;
  logic [9:0]  i_wb_tag;
  logic        i_kill_en;
  logic [3:0]  i_kill_mask;
  logic        o_com_en;
  logic [3:0]  o_com_val;
  logic [27:0] o_com_prd;
  logic [31:0] o_com_pc;

  int n_tests;
  int n_fail;

  rob_nway dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_dis_we    (i_dis_we),
    .i_dis_pc    (i_dis_pc),
    .i_dis_val   (i_dis_val),
    .i_dis_prd   (i_dis_prd),
    .i_dis_brm   (i_dis_brm),
    .o_dis_tag   (o_dis_tag),
    .o_dis_ready (o_dis_ready),
    .i_wb_en     (i_wb_en),
    .i_wb_tag    (i_wb_tag),
    .i_kill_en   (i_kill_en),
    .i_kill_mask (i_kill_mask),
    .o_com_en    (o_com_en),
    .o_com_val   (o_com_val),
    .o_com_prd   (o_com_prd),
    .o_com_pc    (o_com_pc)
  );

  // clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [27:0] p4(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step the active edge and settle 1 ns after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic dis(input logic [31:0] pc, input logic [3:0] val,
                     input logic [27:0] prd, input logic [15:0] brm);
    i_dis_we  = 1'b1;
    i_dis_pc  = pc;
    i_dis_val = val;
    i_dis_prd = prd;
    i_dis_brm = brm;
    tick();
    i_dis_we  = 1'b0;
  endtask

  task automatic wb(input int t0, input int t1);
    i_wb_en  = 2'b11;
    i_wb_tag = {5'(t1), 5'(t0)};
    tick();
    i_wb_en  = 2'b00;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    i_rst_n     = 1'b0;
    i_dis_we    = 1'b0;
    i_dis_pc    = '0;
    i_dis_val   = '0;
    i_dis_prd   = '0;
    i_dis_brm   = '0;
    i_wb_en     = '0;
    i_wb_tag    = '0;
    i_kill_en   = 1'b0;
    i_kill_mask = '0;

    // reset values
    #2;
    chk("rst_ready", 32'(o_dis_ready), 32'd1);
    chk("rst_tag",   32'(o_dis_tag),   32'd0);
    chk("rst_com_en", 32'(o_com_en),   32'd0);
    chk("rst_com_val", 32'(o_com_val), 32'd0);
    #6;
    i_rst_n = 1'b1;
    tick();

    // Fill all 8 rows. Row r has pc r+1 and prd 4r..4r+3, with no writebacks.
    for (int r = 0; r < 8; r++) begin
      dis(32'(r + 1), 4'hF, p4(4*r, 4*r+1, 4*r+2, 4*r+3), 16'h0);
      chk("fill_tag",    32'(o_dis_tag), 32'((r + 1) % 8));
      chk("fill_com_en", 32'(o_com_en),  32'd0);
    end
    chk("full_ready", 32'(o_dis_ready), 32'd0);

    // A 9th dispatch while full is ignored.
    dis(32'd99, 4'hF, p4(9, 9, 9, 9), 16'h0);
    chk("full_ign_tag",   32'(o_dis_tag),   32'd0);
    chk("full_ign_ready", 32'(o_dis_ready), 32'd0);
    chk("head_pc",        o_com_pc,         32'd1);

    // Write back row 0 over two cycles.
    wb(0, 1);
    chk("wb_half_com_en", 32'(o_com_en), 32'd0);
    wb(2, 3);
    chk("wb_com_en",  32'(o_com_en),  32'd1);
    chk("wb_com_val", 32'(o_com_val), 32'hF);
    chk("wb_com_prd", 32'(o_com_prd), 32'(p4(0, 1, 2, 3)));
    chk("wb_com_pc",  o_com_pc,       32'd1);

    // Full ROB plus dispatch while the head commits: only the commit happens.
    dis(32'd200, 4'hF, p4(100, 101, 102, 103), 16'h0);
    chk("fc_ready",  32'(o_dis_ready), 32'd1);
    chk("fc_tag",    32'(o_dis_tag),   32'd0);
    chk("fc_com_en", 32'(o_com_en),    32'd0);
    chk("fc_head_pc", o_com_pc,        32'd2);
    dis(32'd200, 4'hF, p4(100, 101, 102, 103), 16'h0);
    chk("refill_tag",   32'(o_dis_tag),   32'd1);
    chk("refill_ready", 32'(o_dis_ready), 32'd0);

    // Asynchronous reset pulsed between edges.
    #1;
    i_rst_n = 1'b0;
    #0.5;
    chk("arst_ready",   32'(o_dis_ready), 32'd1);
    chk("arst_tag",     32'(o_dis_tag),   32'd0);
    chk("arst_com_en",  32'(o_com_en),    32'd0);
    chk("arst_com_val", 32'(o_com_val),   32'd0);
    #0.5;
    i_rst_n = 1'b1;
    tick();

    // Kill: rows 0 and 1 are on branch 1, row 2 is on branch 0.
    dis(32'd10, 4'hF, p4(1, 2, 3, 4), {4{4'b0010}});
    chk("post_rst_tag", 32'(o_dis_tag), 32'd1);
    chk("post_rst_pc",  o_com_pc,       32'd10);
    chk("k_com_en0",    32'(o_com_en),  32'd0);
    dis(32'd11, 4'hF, p4(5, 6, 7, 8),    {4{4'b0010}});
    dis(32'd12, 4'hF, p4(9, 10, 11, 12), {4{4'b0001}});
    // The kill edge also carries a branch-1 dispatch into row 3.
    i_kill_en   = 1'b1;
    i_kill_mask = 4'b0010;
    dis(32'd13, 4'hF, p4(13, 14, 15, 16), {4{4'b0010}});
    i_kill_en   = 1'b0;
    i_kill_mask = 4'b0000;
    chk("k_r0_com_en",  32'(o_com_en),  32'd1);
    chk("k_r0_com_val", 32'(o_com_val), 32'd0);
    chk("k_r0_pc",      o_com_pc,       32'd10);
    chk("k_tag",        32'(o_dis_tag), 32'd4);
    tick();
    chk("k_r1_com_en",  32'(o_com_en),  32'd1);
    chk("k_r1_com_val", 32'(o_com_val), 32'd0);
    chk("k_r1_pc",      o_com_pc,       32'd11);
    tick();
    chk("k_r2_wait",    32'(o_com_en),  32'd0);
    chk("k_r2_pc",      o_com_pc,       32'd12);
    wb(8, 9);
    wb(10, 11);
    chk("k_r2_com_en",  32'(o_com_en),  32'd1);
    chk("k_r2_com_val", 32'(o_com_val), 32'hF);
    chk("k_r2_prd",     32'(o_com_prd), 32'(p4(9, 10, 11, 12)));
    tick();
    chk("k_r3_com_en",  32'(o_com_en),  32'd1);
    chk("k_r3_com_val", 32'(o_com_val), 32'd0);
    chk("k_r3_pc",      o_com_pc,       32'd13);
    tick();
    chk("k_empty_com_en", 32'(o_com_en),    32'd0);
    chk("k_empty_ready",  32'(o_dis_ready), 32'd1);
    chk("k_empty_tag",    32'(o_dis_tag),   32'd4);

    // Sparse lanes in row 4: only lanes 0 and 2 are valid.
    dis(32'd20, 4'b0101, p4(40, 41, 42, 43), 16'h0);
    chk("sp_wait",  32'(o_com_en), 32'd0);
    chk("sp_pc",    o_com_pc,      32'd20);
    wb(16, 18);
    chk("sp_com_en",  32'(o_com_en),  32'd1);
    chk("sp_com_val", 32'(o_com_val), 32'b0101);
    chk("sp_com_prd", 32'(o_com_prd), 32'(p4(40, 41, 42, 43)));
    tick();
    chk("sp_done",  32'(o_com_en),  32'd0);
    chk("sp_tag",   32'(o_dis_tag), 32'd5);

    // Writeback on both ports and a kill hit the same entry in one edge.
    dis(32'd30, 4'b0001, p4(50, 0, 0, 0), {4{4'b0001}});
    chk("wk_wait", 32'(o_com_en), 32'd0);
    i_kill_en   = 1'b1;
    i_kill_mask = 4'b0001;
    wb(20, 20);
    i_kill_en   = 1'b0;
    i_kill_mask = 4'b0000;
    chk("wk_com_en",  32'(o_com_en),  32'd1);
    chk("wk_com_val", 32'(o_com_val), 32'd0);
    chk("wk_pc",      o_com_pc,       32'd30);
    tick();
    chk("wk_done",  32'(o_com_en),    32'd0);
    chk("wk_tag",   32'(o_dis_tag),   32'd6);
    chk("wk_ready", 32'(o_dis_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
